// File: rtl/branch_resolve_unit.sv
// Tracks in-flight BHT predictions in a small FIFO and checks each one against the EX-stage outcome.
// Drives the BHT update, and on a mispredict a one-cycle flush, a redirect PC and a saturating mispredict count.
module branch_resolve_unit #(
  parameter int LOWER = 5,
  parameter int PC_W  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             push,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             push_pred,
  input  logic [PC_W-1:0]  push_target,
  input  logic             resolve,
  input  logic             actual_taken,
  input  logic [PC_W-1:0]  actual_target,
  output logic             bht_we,
  output logic [LOWER-1:0] bht_waddr,
  output logic             bht_was_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic             pred_mem [DEPTH];
  logic [PC_W-1:0]  tgt_mem  [DEPTH];

  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic             we_q, we_d, taken_q, taken_d, flush_q, flush_d, ovf_q, ovf_d;
  logic [LOWER-1:0] waddr_q, waddr_d;
  logic [PC_W-1:0]  redir_q, redir_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             enq, deq, mis;
  logic [PC_W-1:0]  head_pc, head_tgt;
  logic             head_pred;

  assign head_pc   = pc_mem[rd_q];
  assign head_pred = pred_mem[rd_q];
  assign head_tgt  = tgt_mem[rd_q];
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign mis       = (head_pred != actual_taken) | (actual_taken & (head_tgt != actual_target));

  // A mispredicting resolve squashes the whole FIFO, including any same-cycle push (wrong path).
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    state_d = state_q;
    we_d    = 1'b0;
    flush_d = 1'b0;
    waddr_d = waddr_q;
    taken_d = taken_q;
    redir_d = redir_q;
    ovf_d   = ovf_q;
    mcnt_d  = mcnt_q;
    enq     = 1'b0;
    deq     = 1'b0;
    if (en) begin
      if (state_q == RECOVER) begin
        state_d = RUN;
      end else begin
        deq = resolve & ~empty;
        if (deq) begin
          we_d    = 1'b1;
          waddr_d = head_pc[LOWER+1:2];
          taken_d = actual_taken;
        end
        if (deq && mis) begin
          flush_d = 1'b1;
          redir_d = actual_taken ? actual_target : head_pc + PC_W'(4);
          rd_d    = '0;
          wr_d    = '0;
          count_d = '0;
          state_d = RECOVER;
          if (mcnt_q != {CNT_W{1'b1}}) mcnt_d = mcnt_q + CNT_W'(1);
        end else begin
          if (push) begin
            if (!full || deq) enq = 1'b1;
            else              ovf_d = 1'b1;
          end
          if (enq) wr_d = wr_q + AW'(1);
          if (deq) rd_d = rd_q + AW'(1);
          if (enq && !deq)      count_d = count_q + (AW+1)'(1);
          else if (!enq && deq) count_d = count_q - (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      state_q <= RUN;
      we_q    <= 1'b0;
      flush_q <= 1'b0;
      waddr_q <= '0;
      taken_q <= 1'b0;
      redir_q <= '0;
      ovf_q   <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      state_q <= state_d;
      we_q    <= we_d;
      flush_q <= flush_d;
      waddr_q <= waddr_d;
      taken_q <= taken_d;
      redir_q <= redir_d;
      ovf_q   <= ovf_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_q]   <= push_pc;
      pred_mem[wr_q] <= push_pred;
      tgt_mem[wr_q]  <= push_target;
    end
  end

  assign bht_we         = we_q;
  assign bht_waddr      = waddr_q;
  assign bht_was_taken  = taken_q;
  assign flush          = flush_q;
  assign redirect_pc    = redir_q;
  assign overflow       = ovf_q;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors checked with immediate assertions.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0, push = 1'b0, push_pred = 1'b0, resolve = 1'b0, actual_taken = 1'b0;
  logic [63:0] push_pc = '0, push_target = '0, actual_target = '0;
  logic        bht_we, bht_was_taken, flush, full, empty, overflow;
  logic [4:0]  bht_waddr;
  logic [63:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  int nChecks = 0;
  int nErrors = 0;

  branch_resolve_unit dut (
    .clk(clk), .arst_n(arst_n), .en(en), .push(push), .push_pc(push_pc),
    .push_pred(push_pred), .push_target(push_target), .resolve(resolve),
    .actual_taken(actual_taken), .actual_target(actual_target), .bht_we(bht_we),
    .bht_waddr(bht_waddr), .bht_was_taken(bht_was_taken), .flush(flush),
    .redirect_pc(redirect_pc), .full(full), .empty(empty), .overflow(overflow),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic e, input logic p, input logic [63:0] pc,
                               input logic pr, input logic [63:0] tg, input logic r,
                               input logic at, input logic [63:0] atg);
    en = e; push = p; push_pc = pc; push_pred = pr; push_target = tg;
    resolve = r; actual_taken = at; actual_target = atg;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    #2;
    checkOutput("rst_we", 64'(bht_we), 64'd0);
    checkOutput("rst_flush", 64'(flush), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_cnt", 64'(mispredict_cnt), 64'd0);
    checkOutput("rst_redir", redirect_pc, 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Correct prediction
    applyStimulus(1, 1, 64'h10, 1, 64'h40, 0, 0, 64'h0);
    checkOutput("t1_notempty", 64'(empty), 64'd0);
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 1, 64'h40);
    checkOutput("t1_we", 64'(bht_we), 64'd1);
    checkOutput("t1_waddr", 64'(bht_waddr), 64'd4);
    checkOutput("t1_taken", 64'(bht_was_taken), 64'd1);
    checkOutput("t1_flush", 64'(flush), 64'd0);
    checkOutput("t1_empty", 64'(empty), 64'd1);
    idle();
    checkOutput("t1_we_pulse", 64'(bht_we), 64'd0);

    // Direction mispredict -> fall-through redirect
    applyStimulus(1, 1, 64'h20, 1, 64'h80, 0, 0, 64'h0);
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("t2_flush", 64'(flush), 64'd1);
    checkOutput("t2_redir", redirect_pc, 64'h24);
    checkOutput("t2_cnt", 64'(mispredict_cnt), 64'd1);
    checkOutput("t2_empty", 64'(empty), 64'd1);
    checkOutput("t2_waddr", 64'(bht_waddr), 64'd8);
    checkOutput("t2_taken", 64'(bht_was_taken), 64'd0);
    idle();
    checkOutput("t2_flush_pulse", 64'(flush), 64'd0);
    checkOutput("t2_redir_hold", redirect_pc, 64'h24);

    // Target mispredict
    applyStimulus(1, 1, 64'h8, 1, 64'h30, 0, 0, 64'h0);
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 1, 64'h50);
    checkOutput("t3_flush", 64'(flush), 64'd1);
    checkOutput("t3_redir", redirect_pc, 64'h50);
    checkOutput("t3_cnt", 64'(mispredict_cnt), 64'd2);
    checkOutput("t3_waddr", 64'(bht_waddr), 64'd2);
    idle();

    // Overfill: 5 pushes into 4 entries, then drain in order
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 64'h100 + 64'(4*i), 1, 64'h1100 + 64'(4*i), 0, 0, 64'h0);
      if (i == 3) begin
        checkOutput("t4_full4", 64'(full), 64'd1);
        checkOutput("t4_noovf", 64'(overflow), 64'd0);
      end
    end
    checkOutput("t4_full5", 64'(full), 64'd1);
    checkOutput("t4_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 1, 64'h1100 + 64'(4*i));
      checkOutput($sformatf("t4_we%0d", i), 64'(bht_we), 64'd1);
      checkOutput($sformatf("t4_waddr%0d", i), 64'(bht_waddr), 64'(i));
      checkOutput($sformatf("t4_flush%0d", i), 64'(flush), 64'd0);
    end
    checkOutput("t4_empty", 64'(empty), 64'd1);
    checkOutput("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Mispredict with same-cycle push, then push during RECOVER
    applyStimulus(1, 1, 64'h300, 0, 64'h0, 0, 0, 64'h0);
    applyStimulus(1, 1, 64'h304, 0, 64'h0, 0, 0, 64'h0);
    applyStimulus(1, 1, 64'h308, 0, 64'h0, 0, 0, 64'h0);
    applyStimulus(1, 1, 64'h30C, 0, 64'h0, 1, 1, 64'h400);
    checkOutput("t5_flush", 64'(flush), 64'd1);
    checkOutput("t5_redir", redirect_pc, 64'h400);
    checkOutput("t5_empty", 64'(empty), 64'd1);
    checkOutput("t5_cnt", 64'(mispredict_cnt), 64'd3);
    applyStimulus(1, 1, 64'h310, 0, 64'h0, 0, 0, 64'h0);
    checkOutput("t5_recover_push", 64'(empty), 64'd1);
    checkOutput("t5_recover_flush", 64'(flush), 64'd0);
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("t5_resolve_empty", 64'(bht_we), 64'd0);

    // Stall during resolve
    applyStimulus(1, 1, 64'h514, 0, 64'h0, 0, 0, 64'h0);
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("t6_stall_we", 64'(bht_we), 64'd0);
    checkOutput("t6_stall_empty", 64'(empty), 64'd0);
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("t6_we", 64'(bht_we), 64'd1);
    checkOutput("t6_waddr", 64'(bht_waddr), 64'd5);
    checkOutput("t6_flush", 64'(flush), 64'd0);
    checkOutput("t6_empty", 64'(empty), 64'd1);

    // Push+resolve while full keeps the count
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 64'h600 + 64'(4*i), 0, 64'h0, 0, 0, 64'h0);
    applyStimulus(1, 1, 64'h610, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("t7_full", 64'(full), 64'd1);
    checkOutput("t7_waddr", 64'(bht_waddr), 64'd0);
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("t7_waddr2", 64'(bht_waddr), 64'd1);
    checkOutput("t7_notfull", 64'(full), 64'd0);

    // Async reset right after a pulse
    #2 arst_n = 1'b0;
    #1;
    checkOutput("t8_we", 64'(bht_we), 64'd0);
    checkOutput("t8_empty", 64'(empty), 64'd1);
    checkOutput("t8_ovf", 64'(overflow), 64'd0);
    checkOutput("t8_cnt", 64'(mispredict_cnt), 64'd0);
    checkOutput("t8_redir", redirect_pc, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
